jtvigil_pcm: RTL and testbench

- PCM sample engine for the Vigilante sound board; lives inside the sound subsystem between the sound Z80 I/O decoder and the SDRAM PCM ROM port (pcm_addr/pcm_cs/pcm_data/pcm_ok).
- Holds the 16-bit sample address counter and prefetches the byte at that address from ROM.
- Stalls the Z80 on sample reads until the byte is valid, and drives the 8-bit DAC value into the sound mixer.

---
 rtl/jtvigil_snd_pkg.sv | 15 +
 rtl/jtvigil_pcm_fetch.sv | 82 ++++++++
 rtl/jtvigil_pcm.sv | 97 +++++++++
 tb/tb_jtvigil_pcm.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_snd_pkg.sv
// Shared definitions for the Vigilante sound board: PCM port indexes and fetch FSM states.
package jtvigil_snd_pkg;

    localparam logic [2:0] PCM_ADRL = 3'd0;
    localparam logic [2:0] PCM_ADRH = 3'd1;
    localparam logic [2:0] PCM_DAC  = 3'd2;
    localparam logic [2:0] PCM_RD   = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } pcm_state_t;

endpackage

// File: rtl/jtvigil_pcm_fetch.sv
// Prefetches the PCM ROM byte at the current sample address and flags it valid.
module jtvigil_pcm_fetch #(
    parameter int unsigned OKDLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        addr_chg,
    output logic [15:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [7:0]  data,
    output logic        valid
);
    import jtvigil_snd_pkg::*;

    localparam int unsigned CW  = (OKDLY < 2) ? 1 : $clog2(OKDLY + 1);
    localparam logic [CW-1:0] DLY = CW'(OKDLY);

    pcm_state_t    state, next_state;
    logic [CW-1:0] cnt;
    logic          valid_r;
    logic          accept;
    logic          load;

    assign rom_addr = addr;
    // An address change hides the old byte immediately, before valid_r clears.
    assign valid    = valid_r & ~addr_chg;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        rom_cs     = 1'b0;
        case (state)
            IDLE: begin
                next_state = FETCH;
                load       = 1'b1;
            end
            FETCH: begin
                rom_cs = 1'b1;
                if (addr_chg) begin
                    load = 1'b1;
                end else if (rom_ok && cnt == '0) begin
                    accept     = 1'b1;
                    next_state = VALID;
                end
            end
            VALID: begin
                if (addr_chg) begin
                    next_state = FETCH;
                    load       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            data    <= '0;
            valid_r <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                cnt <= DLY;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (accept) begin
                data    <= rom_data;
                valid_r <= 1'b1;
            end else if (addr_chg) begin
                valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtvigil_pcm.sv
// Vigilante PCM engine: Z80 port decode, sample address counter, DAC and read stall.
module jtvigil_pcm #(
    parameter int unsigned OKDLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        io_addr,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              wait_n,
    output logic [15:0]       rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic signed [7:0] snd,
    output logic              sample
);
    import jtvigil_snd_pkg::*;

    logic        wr_l, rd_l;
    logic        wr_edge, rd_edge;
    logic        addr_chg;
    logic        rd_act, rd_req, take;
    logic        arm;
    logic [15:0] addr;
    logic [7:0]  dac;
    logic [7:0]  din_r;
    logic [7:0]  data;
    logic        valid;

    assign wr_edge  = io_wr & ~wr_l;
    assign rd_edge  = io_rd & ~rd_l;
    assign addr_chg = wr_edge && (io_addr == PCM_ADRL || io_addr == PCM_ADRH || io_addr == PCM_DAC);

    // A sample read stays pending (arm) from its edge until the byte is handed over.
    assign rd_act  = io_rd && (io_addr == PCM_RD);
    assign rd_req  = rd_act && (arm || rd_edge);
    assign take    = rd_req && valid;
    assign wait_n  = !(rd_req && !valid);
    assign cpu_din = (io_rd && io_addr != PCM_RD) ? 8'hFF : (take ? data : din_r);
    assign snd     = {~dac[7], dac[6:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            // Edge registers start high so levels held across reset are not seen as edges.
            wr_l   <= 1'b1;
            rd_l   <= 1'b1;
            addr   <= '0;
            dac    <= 8'h80;
            sample <= 1'b0;
            arm    <= 1'b0;
            din_r  <= '0;
        end else begin
            wr_l   <= io_wr;
            rd_l   <= io_rd;
            sample <= 1'b0;
            if (wr_edge) begin
                case (io_addr)
                    PCM_ADRL: addr[7:0]  <= cpu_dout;
                    PCM_ADRH: addr[15:8] <= cpu_dout;
                    PCM_DAC: begin
                        dac    <= cpu_dout;
                        addr   <= addr + 16'd1;
                        sample <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (take) begin
                din_r <= data;
                arm   <= 1'b0;
            end else if (rd_act && rd_edge) begin
                arm <= 1'b1;
            end else if (!io_rd) begin
                arm <= 1'b0;
            end
        end
    end

    jtvigil_pcm_fetch #(
        .OKDLY(OKDLY)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .addr_chg (addr_chg),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .data     (data),
        .valid    (valid)
    );

endmodule

// File: tb/tb_jtvigil_pcm.sv
// Directed bench for jtvigil_pcm with a latency-programmable PCM ROM model.
module tb_jtvigil_pcm;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        io_addr;
    logic              io_wr;
    logic              io_rd;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              wait_n;
    logic [15:0]       rom_addr;
    logic              rom_cs;
    logic [7:0]        rom_data;
    logic              rom_ok;
    logic signed [7:0] snd;
    logic              sample;

    int vectors     = 0;
    int miscompares = 0;

    logic        auto_ok = 1'b1;
    logic        man_ok  = 1'b0;
    logic [7:0]  man_data = 8'h00;
    logic        mdl_ok  = 1'b0;
    logic [7:0]  mdl_data = 8'h00;
    int          rom_lat = 2;
    logic        busy    = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    int          mcnt    = 0;
    int          scount  = 0;

    always #5 clk = ~clk;

    jtvigil_pcm #(
        .OKDLY(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .wait_n   (wait_n),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .snd      (snd),
        .sample   (sample)
    );

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        case (a)
            16'h1234: rom_fn = 8'hA5;
            16'h5678: rom_fn = 8'h3C;
            default:  rom_fn = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    assign rom_ok   = auto_ok ? mdl_ok   : man_ok;
    assign rom_data = auto_ok ? mdl_data : man_data;

    // ROM answers rom_lat cycles after it first sees a request for an address.
    always @(negedge clk) begin
        if (!auto_ok || !rom_cs) begin
            busy   = 1'b0;
            mdl_ok = 1'b0;
        end else if (busy && rom_addr == req_addr) begin
            if (mcnt < rom_lat) mcnt++;
            if (mcnt >= rom_lat) begin
                mdl_ok   = 1'b1;
                mdl_data = rom_fn(req_addr);
            end
        end else begin
            busy     = 1'b1;
            req_addr = rom_addr;
            mcnt     = 0;
            mdl_ok   = 1'b0;
        end
    end

    always @(negedge clk) if (sample === 1'b1) scount++;

    task automatic wr(input logic [2:0] p, input logic [7:0] d);
        @(negedge clk);
        io_addr  = p;
        cpu_dout = d;
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        #1;
        while (rom_cs !== 1'b0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (rom_cs !== 1'b0) begin
            miscompares++;
            $display("FAIL %s fetch_timeout: rom_cs=%b required 0", nm, rom_cs);
        end
    endtask

    task automatic rd4(input string nm, input logic [7:0] exp, input int min_stall, input int max_stall);
        int n = 0;
        @(negedge clk);
        io_addr = 3'd4;
        io_rd   = 1'b1;
        #1;
        while (wait_n !== 1'b1 && n < 30) begin
            n++;
            @(negedge clk); #1;
        end
        vectors++;
        if (wait_n !== 1'b1) begin
            miscompares++;
            $display("FAIL %s wait_timeout: wait_n=%b required 1", nm, wait_n);
        end
        vectors++;
        if (n < min_stall || n > max_stall) begin
            miscompares++;
            $display("FAIL %s stall: %0d cycles, required %0d..%0d", nm, n, min_stall, max_stall);
        end
        vectors++;
        if (cpu_din !== exp) begin
            miscompares++;
            $display("FAIL %s data: cpu_din=%h required %h", nm, cpu_din, exp);
        end
        @(negedge clk); #1;
        vectors++;
        if (cpu_din !== exp || wait_n !== 1'b1) begin
            miscompares++;
            $display("FAIL %s hold: cpu_din=%h wait_n=%b required %h 1", nm, cpu_din, wait_n, exp);
        end
        io_rd = 1'b0;
        #1;
        vectors++;
        if (cpu_din !== exp) begin
            miscompares++;
            $display("FAIL %s after_rd: cpu_din=%h required %h", nm, cpu_din, exp);
        end
    endtask

    task automatic test_reset;
        int n = 0;
        rst = 1'b1; io_addr = 3'd0; io_wr = 1'b0; io_rd = 1'b0; cpu_dout = 8'h00;
        auto_ok = 1'b1; rom_lat = 2;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL rst_rom_cs: got %b required 0", rom_cs); end
        vectors++;
        if (wait_n !== 1'b1) begin miscompares++; $display("FAIL rst_wait_n: got %b required 1", wait_n); end
        vectors++;
        if (cpu_din !== 8'h00) begin miscompares++; $display("FAIL rst_cpu_din: got %h required 00", cpu_din); end
        vectors++;
        if (sample !== 1'b0) begin miscompares++; $display("FAIL rst_sample: got %b required 0", sample); end
        vectors++;
        if (snd !== 8'sh00) begin miscompares++; $display("FAIL rst_snd: got %h required 00", snd); end
        rst = 1'b0;
        @(negedge clk); #1;
        while (rom_cs !== 1'b1 && n < 5) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (rom_cs !== 1'b1 || rom_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL first_fetch: rom_cs=%b rom_addr=%h required 1 0000", rom_cs, rom_addr);
        end
        wait_idle("first_fetch");
        vectors++;
        if (snd !== 8'sh00) begin miscompares++; $display("FAIL idle_snd: got %h required 00", snd); end
        rd4("rd_0000", 8'h5A, 0, 0);
    endtask

    task automatic test_other_ports;
        int sc = scount;
        wr(3'd3, 8'h99);
        #1;
        vectors++;
        if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL port3_ignored: rom_cs=%b required 0", rom_cs); end
        @(negedge clk);
        io_addr = 3'd5;
        io_rd   = 1'b1;
        #1;
        vectors++;
        if (cpu_din !== 8'hFF || wait_n !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_port5: cpu_din=%h wait_n=%b required FF 1", cpu_din, wait_n);
        end
        @(negedge clk);
        io_rd = 1'b0;
        rd4("rd_again_0000", 8'h5A, 0, 0);
        vectors++;
        if (scount !== sc) begin miscompares++; $display("FAIL no_sample: count=%0d required %0d", scount, sc); end
    endtask

    task automatic test_stall_read;
        wr(3'd0, 8'h34);
        wr(3'd1, 8'h12);
        rd4("rd_1234", 8'hA5, 2, 30);
    endtask

    task automatic test_wrap;
        int sc;
        wr(3'd0, 8'hFF);
        wr(3'd1, 8'hFF);
        wait_idle("fetch_ffff");
        sc = scount;
        wr(3'd2, 8'h00);
        #1;
        vectors++;
        if (snd !== 8'sh80) begin miscompares++; $display("FAIL wrap_snd: got %h required 80", snd); end
        vectors++;
        if (rom_cs !== 1'b1 || rom_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_fetch: rom_cs=%b rom_addr=%h required 1 0000", rom_cs, rom_addr);
        end
        vectors++;
        if (sample !== 1'b1) begin miscompares++; $display("FAIL wrap_pulse: got %b required 1", sample); end
        @(negedge clk); #1;
        vectors++;
        if (sample !== 1'b0) begin miscompares++; $display("FAIL wrap_pulse_end: got %b required 0", sample); end
        wait_idle("fetch_0000");
        vectors++;
        if (scount !== sc + 1) begin miscompares++; $display("FAIL wrap_pulses: count=%0d required %0d", scount, sc + 1); end
        rd4("rd_wrap", 8'h5A, 0, 0);
    endtask

    task automatic test_held_write;
        int sc = scount;
        @(negedge clk);
        io_addr  = 3'd2;
        cpu_dout = 8'h7F;
        io_wr    = 1'b1;
        repeat (10) @(negedge clk);
        io_wr = 1'b0;
        #1;
        vectors++;
        if (snd !== 8'shFF) begin miscompares++; $display("FAIL held_snd: got %h required FF", snd); end
        wait_idle("fetch_0001");
        vectors++;
        if (scount !== sc + 1) begin miscompares++; $display("FAIL held_pulses: count=%0d required %0d", scount, sc + 1); end
        rd4("rd_0001", 8'h5B, 0, 0);
    endtask

    task automatic test_stale_ok;
        auto_ok = 1'b0;
        man_ok  = 1'b0;
        wr(3'd0, 8'h34);
        wr(3'd1, 8'h12);
        @(negedge clk);
        man_ok   = 1'b1;
        man_data = 8'hA5;
        io_addr  = 3'd0;
        cpu_dout = 8'h78;
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        #1;
        vectors++;
        if (rom_cs !== 1'b1 || rom_addr !== 16'h1278) begin
            miscompares++;
            $display("FAIL ok_vs_chg: rom_cs=%b rom_addr=%h required 1 1278", rom_cs, rom_addr);
        end
        @(negedge clk); #1;
        vectors++;
        if (rom_cs !== 1'b1) begin miscompares++; $display("FAIL okdly_guard: rom_cs=%b required 1", rom_cs); end
        man_ok = 1'b0;
        wr(3'd1, 8'h56);
        auto_ok = 1'b1;
        rd4("rd_5678", 8'h3C, 1, 30);
    endtask

    task automatic test_reset_mid_fetch;
        rom_lat = 8;
        wr(3'd0, 8'h11);
        @(negedge clk);
        io_addr = 3'd4;
        io_rd   = 1'b1;
        #1;
        vectors++;
        if (wait_n !== 1'b0) begin miscompares++; $display("FAIL pre_rst_stall: wait_n=%b required 0", wait_n); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rom_cs: got %b required 0", rom_cs); end
        vectors++;
        if (wait_n !== 1'b1) begin miscompares++; $display("FAIL mid_rst_wait_n: got %b required 1", wait_n); end
        vectors++;
        if (rom_addr !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_addr: got %h required 0000", rom_addr); end
        vectors++;
        if (snd !== 8'sh00) begin miscompares++; $display("FAIL mid_rst_snd: got %h required 00", snd); end
        vectors++;
        if (cpu_din !== 8'h00) begin miscompares++; $display("FAIL mid_rst_cpu_din: got %h required 00", cpu_din); end
        rst     = 1'b0;
        io_rd   = 1'b0;
        rom_lat = 2;
        @(negedge clk);
        wait_idle("post_rst_fetch");
        rd4("rd_post_rst", 8'h5A, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_other_ports;
        test_stall_read;
        test_wrap;
        test_held_write;
        test_stale_ok;
        test_reset_mid_fetch;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
